// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types for the accumulator-machine control sequencer.
// Holds opcodes, FSM states, ALU op codes, instruction fields, decode bundle.
package ctrl_pkg;

  localparam int INSTR_OPCODE_MSB = 15;
  localparam int INSTR_OPCODE_LSB = 12;
  localparam int INSTR_IND_BIT    = 11;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_LOAD   = 4'h1,
    OP_STORE  = 4'h2,
    OP_ADD    = 4'h3,
    OP_SUB    = 4'h4,
    OP_AND    = 4'h5,
    OP_OR     = 4'h6,
    OP_XOR    = 4'h7,
    OP_JUMP   = 4'h8,
    OP_JZ     = 4'h9,
    OP_SHL    = 4'hA,
    OP_SHR    = 4'hB,
    OP_JN     = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_HALT   = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_FWAIT,
    ST_DECODE,
    ST_OPRD,
    ST_OPWAIT,
    ST_EXEC,
    ST_STORE,
    ST_HALT,
    ST_IND,
    ST_INDWAIT
  } state_e;

  typedef enum logic [1:0] {
    COND_ALWAYS,
    COND_ZERO,
    COND_NEG
  } cond_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SHL = 4'b0100;
  localparam logic [3:0] ALU_SHR = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       is_jump;
    cond_e      jump_cond;
    logic [3:0] alu_op;
    logic       halt;
    logic       is_load;
    logic       is_shift;
  } dec_t;

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: memory port and ALU port of the control sequencer.
// master: mem_addr/mem_wdata/mem_we/alu_op/alu_a/alu_b out; mem_rdata/alu_result in.
interface control_sequencer_if;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output alu_op,
    output alu_a,
    output alu_b,
    input  mem_rdata,
    input  alu_result
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  alu_op,
    input  alu_a,
    input  alu_b,
    output mem_rdata,
    output alu_result
  );

endinterface

// File: rtl/control_sequencer_instr_decoder.sv
// instr_decoder: combinational map from IR to the control bundle dec_t.
// Ports: ir (in, 16) instruction register; dec (out) decoded controls.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  opcode_e op;

  assign op = opcode_e'(ir[INSTR_OPCODE_MSB:INSTR_OPCODE_LSB]);

  always_comb begin
    dec           = '0;
    dec.jump_cond = COND_ALWAYS;
    dec.alu_op    = ALU_ADD;
    unique case (op)
      OP_LOAD: begin
        dec.mem_read = 1'b1;
        dec.is_load  = 1'b1;
      end
      OP_STORE: dec.mem_write = 1'b1;
      OP_ADD: begin
        dec.mem_read = 1'b1;
        dec.alu_op   = ALU_ADD;
      end
      OP_SUB: begin
        dec.mem_read = 1'b1;
        dec.alu_op   = ALU_SUB;
      end
      OP_AND: begin
        dec.mem_read = 1'b1;
        dec.alu_op   = ALU_AND;
      end
      OP_OR: begin
        dec.mem_read = 1'b1;
        dec.alu_op   = ALU_OR;
      end
      OP_XOR: begin
        dec.mem_read = 1'b1;
        dec.alu_op   = ALU_XOR;
      end
      OP_JUMP: dec.is_jump = 1'b1;
      OP_JZ: begin
        dec.is_jump   = 1'b1;
        dec.jump_cond = COND_ZERO;
      end
      OP_JN: begin
        dec.is_jump   = 1'b1;
        dec.jump_cond = COND_NEG;
      end
      OP_SHL: begin
        dec.is_shift = 1'b1;
        dec.alu_op   = ALU_SHL;
      end
      OP_SHR: begin
        dec.is_shift = 1'b1;
        dec.alu_op   = ALU_SHR;
      end
      OP_HALT: dec.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multicycle fetch/decode/execute controller owning PC/IR/MBR/AC.
// Ports: clk, reset (async high); bus (master: memory + ALU); pc/ac/ir/halted debug.
// Build option CTRL_INDIRECT_EN: IR[11] selects indirect addressing via IND/INDWAIT.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int          MEM_DEPTH = 16384,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  control_sequencer_if.master bus,
  output logic [15:0]         pc,
  output logic [15:0]         ac,
  output logic [15:0]         ir,
  output logic                halted
);

  state_e      state;
  state_e      state_d;
  logic [15:0] pc_d;
  logic [15:0] ir_d;
  logic [15:0] ac_d;
  logic [15:0] mbr;
  logic [15:0] mbr_d;
  logic [15:0] addr_q;
  logic [15:0] addr_d;
  logic [15:0] wdata_q;
  logic [15:0] wdata_d;
  logic        we_q;
  logic        we_d;
  logic [15:0] pc_inc;
  logic [15:0] opnd;
  logic [15:0] eff;
  logic        taken;
  logic        dispatch;
  dec_t        dec;

  function automatic logic [15:0] wrap(input logic [15:0] a);
    return 16'(32'(a) % 32'(MEM_DEPTH));
  endfunction

  instr_decoder u_dec (
    .ir  (ir),
    .dec (dec)
  );

  assign pc_inc = (32'(pc) == 32'(MEM_DEPTH - 1)) ? 16'h0 : pc + 16'h1;

`ifdef CTRL_INDIRECT_EN
  logic ind;
  logic refs_mem;

  assign opnd     = {5'd0, ir[10:0]};
  assign ind      = ir[INSTR_IND_BIT];
  assign refs_mem = dec.mem_read | dec.mem_write | dec.is_jump;
  // In INDWAIT the pointer word just read becomes the effective address.
  assign eff      = wrap((state == ST_INDWAIT) ? bus.mem_rdata : opnd);
`else
  assign opnd = {4'd0, ir[11:0]};
  assign eff  = wrap(opnd);
`endif

  always_comb begin
    taken = 1'b1;
    unique case (dec.jump_cond)
      COND_ZERO: taken = (ac == 16'h0);
      COND_NEG:  taken = ac[15];
      default:   taken = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state;
    pc_d     = pc;
    ir_d     = ir;
    ac_d     = ac;
    mbr_d    = mbr;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    dispatch = 1'b0;
    unique case (state)
      ST_FETCH: state_d = ST_FWAIT;
      ST_FWAIT: begin
        ir_d    = bus.mem_rdata;
        pc_d    = pc_inc;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec.halt) begin
          state_d = ST_HALT;
        end else if (dec.is_shift) begin
          ac_d    = bus.alu_result;
          state_d = ST_FETCH;
        end
`ifdef CTRL_INDIRECT_EN
        else if (ind && refs_mem) begin
          addr_d  = eff;
          state_d = ST_IND;
        end
`endif
        else begin
          dispatch = 1'b1;
        end
      end
      ST_OPRD: state_d = ST_OPWAIT;
      ST_OPWAIT: begin
        mbr_d   = bus.mem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        ac_d    = dec.is_load ? mbr : bus.alu_result;
        state_d = ST_FETCH;
      end
      ST_STORE: state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
`ifdef CTRL_INDIRECT_EN
      ST_IND:     state_d = ST_INDWAIT;
      ST_INDWAIT: dispatch = 1'b1;
`endif
      default: state_d = ST_FETCH;
    endcase

    // Route a decoded instruction once its effective address is known.
    if (dispatch) begin
      if (dec.mem_read) begin
        addr_d  = eff;
        state_d = ST_OPRD;
      end else if (dec.mem_write) begin
        addr_d  = eff;
        wdata_d = ac;
        we_d    = 1'b1;
        state_d = ST_STORE;
      end else if (dec.is_jump && taken) begin
        pc_d    = eff;
        state_d = ST_FETCH;
      end else begin
        state_d = ST_FETCH;
      end
    end

    // Address is registered, so it is loaded on the way into FETCH.
    if (state_d == ST_FETCH) addr_d = pc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      ir      <= 16'h0;
      ac      <= 16'h0;
      mbr     <= 16'h0;
      addr_q  <= RESET_PC;
      wdata_q <= 16'h0;
      we_q    <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      ir      <= ir_d;
      ac      <= ac_d;
      mbr     <= mbr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.alu_op    = dec.alu_op;
  assign bus.alu_a     = ac;
  assign bus.alu_b     = mbr;
  assign halted        = (state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed programs with a cycle-tagged scoreboard.
// Stimulus pushes expectations; a negedge monitor compares and pops them.
`timescale 1ns/1ps
module tb_control_sequencer;

  localparam int P_PC    = 0;
  localparam int P_AC    = 1;
  localparam int P_IR    = 2;
  localparam int P_ADDR  = 3;
  localparam int P_WE    = 4;
  localparam int P_HALT  = 5;
  localparam int P_ALUOP = 6;
  localparam int P_WDATA = 7;
  localparam int P_MEM   = 8;
  localparam int P_SPC   = 9;
  localparam int P_SAC   = 10;
  localparam int P_SADDR = 11;
  localparam int P_SHALT = 12;

  typedef struct {
    int          cyc;
    int          sel;
    int          addr;
    logic [15:0] val;
    string       name;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_sequencer_if bus ();
  control_sequencer_if sbus ();

  logic [15:0] pc, ac, ir;
  logic        halted;
  logic [15:0] spc, sac, sir;
  logic        shalted;

  control_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .pc     (pc),
    .ac     (ac),
    .ir     (ir),
    .halted (halted)
  );

  control_sequencer #(
    .MEM_DEPTH (16),
    .RESET_PC  (16'd15)
  ) dut_small (
    .clk    (clk),
    .reset  (reset),
    .bus    (sbus),
    .pc     (spc),
    .ac     (sac),
    .ir     (sir),
    .halted (shalted)
  );

  logic [15:0] mem [0:16383];
  logic        ld_en = 1'b0;
  logic [13:0] ld_addr = '0;
  logic [15:0] ld_data = '0;

  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr[13:0]];
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_we) mem[bus.mem_addr[13:0]] <= bus.mem_wdata;
  end

  always_comb begin
    case (bus.alu_op)
      4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_a - bus.alu_b;
      4'b0100: bus.alu_result = bus.alu_a << 1;
      4'b0101: bus.alu_result = bus.alu_a >> 1;
      4'b1000: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b1001: bus.alu_result = bus.alu_a | bus.alu_b;
      4'b1010: bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: bus.alu_result = 16'h0;
    endcase
  end

  // 16-word ROM: M[15]=LOAD 0x012 (wraps to 2), M[2]=ABCD, else HALT.
  always @(posedge clk) begin
    case (sbus.mem_addr[3:0])
      4'd15:   sbus.mem_rdata <= 16'h1012;
      4'd2:    sbus.mem_rdata <= 16'hABCD;
      default: sbus.mem_rdata <= 16'hF000;
    endcase
  end
  assign sbus.alu_result = sbus.alu_a + sbus.alu_b;

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  exp_t eq[$];
  wr_t  wq[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [15:0] probe(input int sel, input int a);
    case (sel)
      P_PC:    return pc;
      P_AC:    return ac;
      P_IR:    return ir;
      P_ADDR:  return bus.mem_addr;
      P_WE:    return {15'd0, bus.mem_we};
      P_HALT:  return {15'd0, halted};
      P_ALUOP: return {12'd0, bus.alu_op};
      P_WDATA: return bus.mem_wdata;
      P_MEM:   return mem[a[13:0]];
      P_SPC:   return spc;
      P_SAC:   return sac;
      P_SADDR: return sbus.mem_addr;
      P_SHALT: return {15'd0, shalted};
      default: return 16'hDEAD;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [15:0] act;
    wr_t w;
    if (bus.mem_we) begin
      vectors++;
      if (wq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr=%h data=%h, none expected",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        w = wq.pop_front();
        if (bus.mem_addr !== w.addr || bus.mem_wdata !== w.data) begin
          miscompares++;
          $display("FAIL store: got addr=%h data=%h, expected addr=%h data=%h",
                   bus.mem_addr, bus.mem_wdata, w.addr, w.data);
        end
      end
    end
    for (int i = eq.size() - 1; i >= 0; i--) begin
      if (eq[i].cyc == cyc) begin
        act = probe(eq[i].sel, eq[i].addr);
        vectors++;
        if (act !== eq[i].val) begin
          miscompares++;
          $display("FAIL %s: got %h, expected %h (cycle %0d)",
                   eq[i].name, act, eq[i].val, cyc);
        end
        eq.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int s, input logic [15:0] v,
                           input string n, input int a = 0);
    exp_t e;
    e.cyc  = c;
    e.sel  = s;
    e.addr = a;
    e.val  = v;
    e.name = n;
    eq.push_back(e);
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  task automatic load(input logic [13:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic enter_reset();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input int last, input string tname);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cyc >= last && eq.size() == 0 && wq.size() == 0) break;
    end
    while (eq.size() != 0) begin
      miscompares++;
      $display("FAIL %s/%s: never sampled, expected %h at cycle %0d",
               tname, eq[0].name, eq[0].val, eq[0].cyc);
      void'(eq.pop_front());
    end
    while (wq.size() != 0) begin
      miscompares++;
      $display("FAIL %s/store: no write seen, expected addr=%h data=%h",
               tname, wq[0].addr, wq[0].data);
      void'(wq.pop_front());
    end
  endtask

  initial begin
    // Program A: LOAD, ADD, STORE, HALT; small core wraps PC and operand.
    enter_reset();
    load(14'h0000, 16'h1010);
    load(14'h0001, 16'h3011);
    load(14'h0002, 16'h2012);
    load(14'h0003, 16'hF000);
    load(14'h0010, 16'h0005);
    load(14'h0011, 16'h0007);
    expect_at(0, P_PC, 16'h0000, "rst_pc");
    expect_at(0, P_AC, 16'h0000, "rst_ac");
    expect_at(0, P_IR, 16'h0000, "rst_ir");
    expect_at(0, P_ADDR, 16'h0000, "rst_addr");
    expect_at(0, P_WE, 16'h0000, "rst_we");
    expect_at(0, P_HALT, 16'h0000, "rst_halted");
    expect_at(0, P_ALUOP, 16'h0000, "rst_aluop");
    expect_at(0, P_WDATA, 16'h0000, "rst_wdata");
    expect_at(0, P_SPC, 16'h000F, "small_rst_pc");
    expect_at(2, P_IR, 16'h1010, "a_ir_load");
    expect_at(2, P_PC, 16'h0001, "a_pc_inc");
    expect_at(6, P_AC, 16'h0005, "a_ac_load");
    expect_at(12, P_AC, 16'h000C, "a_ac_add");
    expect_at(18, P_HALT, 16'h0000, "a_not_yet_halted");
    expect_at(19, P_HALT, 16'h0001, "a_halted");
    expect_at(19, P_PC, 16'h0004, "a_pc_halt");
    expect_at(20, P_MEM, 16'h000C, "a_mem12", 16'h12);
    expect_at(25, P_PC, 16'h0004, "a_halt_absorb");
    expect_at(1, P_SPC, 16'h000F, "small_pc_fwait");
    expect_at(2, P_SPC, 16'h0000, "small_pc_wrap");
    expect_at(3, P_SADDR, 16'h0002, "small_opnd_wrap");
    expect_at(6, P_SAC, 16'hABCD, "small_ac");
    expect_at(6, P_SADDR, 16'h0000, "small_fetch_addr");
    expect_at(9, P_SHALT, 16'h0001, "small_halted");
    expect_wr(16'h0012, 16'h000C);
    release_reset();
    drain(26, "progA");

    // JZ taken with AC=0.
    enter_reset();
    load(14'h0000, 16'h9005);
    load(14'h0005, 16'hF000);
    expect_at(2, P_PC, 16'h0001, "jz_pc_inc");
    expect_at(3, P_PC, 16'h0005, "jz_taken_pc");
    expect_at(3, P_ADDR, 16'h0005, "jz_taken_addr");
    expect_at(5, P_HALT, 16'h0000, "jz_pre_halt");
    expect_at(6, P_HALT, 16'h0001, "jz_halted");
    release_reset();
    drain(7, "jz_taken");

    // JZ not taken with AC=1.
    enter_reset();
    load(14'h0000, 16'h1006);
    load(14'h0001, 16'h9005);
    load(14'h0002, 16'hF000);
    load(14'h0006, 16'h0001);
    expect_at(6, P_AC, 16'h0001, "jzn_ac");
    expect_at(9, P_PC, 16'h0002, "jzn_pc");
    expect_at(9, P_ADDR, 16'h0002, "jzn_addr");
    expect_at(12, P_HALT, 16'h0001, "jzn_halted");
    release_reset();
    drain(13, "jz_not_taken");

    // SHL 8001 -> 0002; 0 - 1 -> FFFF; JN taken.
    enter_reset();
    load(14'h0000, 16'h1008);
    load(14'h0001, 16'hA000);
    load(14'h0002, 16'h1009);
    load(14'h0003, 16'h400A);
    load(14'h0004, 16'hC007);
    load(14'h0007, 16'hF000);
    load(14'h0008, 16'h8001);
    load(14'h0009, 16'h0000);
    load(14'h000A, 16'h0001);
    expect_at(8, P_ALUOP, 16'h0004, "shl_aluop");
    expect_at(9, P_AC, 16'h0002, "shl_ac");
    expect_at(15, P_AC, 16'h0000, "ld0_ac");
    expect_at(20, P_ALUOP, 16'h0001, "sub_aluop");
    expect_at(21, P_AC, 16'hFFFF, "sub_ac");
    expect_at(24, P_PC, 16'h0007, "jn_taken_pc");
    expect_at(27, P_HALT, 16'h0001, "jn_halted");
    release_reset();
    drain(28, "alu");

    // Reset pulsed while in STORE: write must not land.
    enter_reset();
    load(14'h0000, 16'h1006);
    load(14'h0001, 16'h2007);
    load(14'h0006, 16'h1234);
    load(14'h0007, 16'hAAAA);
    expect_at(6, P_AC, 16'h1234, "ms_ac");
    release_reset();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (cyc == 9) break;
    end
    if (cyc != 9) begin
      miscompares++;
      $display("FAIL ms_reach_store: got cycle %0d, expected 9", cyc);
    end
    expect_at(0, P_WE, 16'h0000, "ms_we");
    expect_at(0, P_PC, 16'h0000, "ms_pc");
    expect_at(0, P_AC, 16'h0000, "ms_ac_rst");
    expect_at(0, P_ADDR, 16'h0000, "ms_addr");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    expect_at(0, P_MEM, 16'hAAAA, "ms_target_kept", 7);
    drain(0, "mid_store");

`ifdef CTRL_INDIRECT_EN
    // Indirect LOAD through M[0x20] -> M[0x30].
    enter_reset();
    load(14'h0000, 16'h1820);
    load(14'h0001, 16'hF000);
    load(14'h0020, 16'h0030);
    load(14'h0030, 16'hBEEF);
    expect_at(3, P_ADDR, 16'h0020, "ind_ptr_addr");
    expect_at(5, P_ADDR, 16'h0030, "ind_eff_addr");
    expect_at(7, P_AC, 16'h0000, "ind_ac_pre");
    expect_at(8, P_AC, 16'hBEEF, "ind_ac");
    expect_at(11, P_HALT, 16'h0001, "ind_halted");
    release_reset();
    drain(12, "indirect");
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
